// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: nibble-serial add/subtract controller sharing one 4-bit adder, LSB nibble first
module serial_add_ctrl #(
    parameter  int N_NIB = 4,
    localparam int W     = 4 * N_NIB
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op_sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy
);
    localparam int IW = (N_NIB > 1) ? $clog2(N_NIB) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        r_state, w_next;
    logic [W-1:0]  r_a, r_b, r_sum;
    logic          r_carry, r_cout;
    logic [IW-1:0] r_idx;
    logic [IW+1:0] w_lsb;
    logic [4:0]    w_add;
    logic          w_last;
    logic          w_accept;
    assign w_lsb    = {r_idx, 2'b00};
    assign w_add    = {1'b0, r_a[w_lsb +: 4]} + {1'b0, r_b[w_lsb +: 4]} + {4'b0, r_carry};
    assign w_last   = (r_idx == IW'(N_NIB - 1));
    assign w_accept = (r_state == IDLE) && in_valid;
    assign sum      = r_sum;
    assign cout     = r_cout;
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next    = w_accept                          ? RUN  :
                    (r_state == RUN  && w_last)       ? DONE :
                    (r_state == DONE && out_ready)    ? IDLE : r_state;
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        busy      = (r_state != IDLE);
    end
    // Subtract is a + ~b + 1, so the carry register doubles as the +1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= op_sub ? ~b : b;
            r_carry <= op_sub;
            r_sum   <= '0;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_sum[w_lsb +: 4] <= w_add[3:0];
            r_carry           <= w_add[4];
            r_idx             <= r_idx + 1'b1;
            if (w_last) r_cout <= w_add[4];
        end
    end
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- N_NIB, 4, number of 4-bit nibbles per operand.
- W, 4*N_NIB, operand/sum width (derived, not overridable).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, operation request.
- in_ready, output, 1, controller can accept a request.
- op_sub, input, 1, 0 = a+b, 1 = a-b.
- a, input, W, first operand.
- b, input, W, second operand.
- out_valid, output, 1, result available.
- out_ready, input, 1, consumer takes the result.
- sum, output, W, result.
- cout, output, 1, carry out of the MSB nibble (not-borrow for subtract).
- busy, output, 1, high in RUN or DONE.
REQ-003 The block SHALL use one clock domain; reset SHALL be synchronous and active-low; there SHALL be no other clock or reset.

Function
REQ-004 The block SHALL share one 4-bit adder with carry-in, one nibble per cycle, LSB nibble first.
REQ-005 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-006 IDLE: in_ready=1, out_valid=0, busy=0.
REQ-007 A request is accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-008 On acceptance the block SHALL:
- latch a and op_sub;
- latch b, or ~b when op_sub=1;
- set carry to op_sub;
- clear sum to 0 and the nibble index to 0;
- move to RUN.
REQ-009 In RUN, on each edge the block SHALL:
- compute {c, s} = a[idx] + b'[idx] + carry;
- write s into sum nibble idx;
- load c into carry;
- increment idx.
After nibble N_NIB-1 it SHALL move to DONE and set cout to the final carry.
REQ-010 Latency SHALL be exactly N_NIB edges from the accepting edge to out_valid=1.
REQ-011 In RUN, in_ready SHALL be 0 and out_valid SHALL be 0; in_valid and operand changes SHALL be ignored.
REQ-012 DONE:
- out_valid=1, in_ready=0;
- sum and cout held stable while out_ready=0;
- an edge with out_ready=1 SHALL return the FSM to IDLE.
REQ-013 Sum and cout SHALL keep their last value in IDLE until the next acceptance.
REQ-014 Arithmetic SHALL be modulo 2^W; wrap-around is reported only through cout.
REQ-015 Maximum throughput SHALL be one operation per N_NIB+2 cycles (accept, N_NIB RUN edges, DONE handshake).
REQ-016 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-017 When rst_n=0 at a rising edge, on that edge the block SHALL:
- move to IDLE;
- clear sum, cout, carry and idx to 0;
- drive out_valid=0, busy=0 and in_ready=1 after the edge.
REQ-018 Reset SHALL take priority over every other event, including mid-RUN and DONE with out_ready=1.
REQ-019 A request presented on the first edge after rst_n returns to 1 SHALL be accepted normally.

Verification (N_NIB=4)
REQ-020 Add: a=0x1234, b=0x4321, op_sub=0 -> out_valid exactly 4 edges after acceptance, sum=0x5555, cout=0.
REQ-021 Ripple carry: a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1; a=0x0FFF, b=0x0001 -> sum=0x1000, cout=0.
REQ-022 Subtract: 0x0005-0x0007 -> sum=0xFFFE, cout=0; 0x0007-0x0005 -> sum=0x0002, cout=1.
REQ-023 Backpressure: out_ready=0 for 3 cycles in DONE -> sum and cout stable, in_ready=0, and a new in_valid pulse is not accepted.
REQ-024 Reset mid-operation: rst_n=0 on the 2nd RUN edge -> next cycle in_ready=1, out_valid=0, sum=0; a following 0x0001+0x0001 yields 0x0002.
REQ-025 Streaming: in_valid=1 and out_ready=1 held for 20 cycles with random operands -> one accepted request every 6 cycles, every result matches a scoreboard computing a±b mod 2^16 with correct cout.
